// File: rtl/x9dn_sel_pipe.sv
// x9dn_sel_pipe: pipelined address decode, lane select and tag compare with saturating status counters
module x9dn_sel_pipe #(
  parameter int ADDR_W = 6,
  parameter int LANES  = 4,
  parameter int MODE_W = 3,
  parameter int TAG_W  = 7,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [MODE_W-1:0] mode,
  input  logic [LANES-1:0]  lanes,
  input  logic [TAG_W-1:0]  tag,
  input  logic [TAG_W-1:0]  tag_ref,
  input  logic              cnt_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bcast,
  output logic              out_local,
  output logic              out_bit,
  output logic              out_taghit,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  ill_cnt
);
  if (DEPTH < 1 || DEPTH > 4 || (2 ** MODE_W) < LANES) begin : g_bad_param
    $error("x9dn_sel_pipe: DEPTH must be 1..4 and 2**MODE_W >= LANES");
  end
  localparam logic [MODE_W:0] lanes_v = (MODE_W + 1)'(LANES);
  logic [LANES-1:0] sh;
  logic             bc, lc, il, acc, stall, dlv;
  logic [4:0]       dec;
  logic [4:0]       d [DEPTH];
  logic [DEPTH-1:0] v;
  always_comb begin
    bc    = &addr;
    lc    = ~|addr;
    il    = {1'b0, mode} >= lanes_v;
    sh    = lanes >> mode;
    dec   = {bc, lc, sh[0] & (bc | lc) & ~il, tag == tag_ref, il};
    stall = out_valid & ~out_ready;
    acc   = in_valid & in_ready;
    dlv   = out_valid & out_ready;
  end
  assign out_valid = v[DEPTH-1];
  assign in_ready  = ~stall;
  assign {out_bcast, out_local, out_bit, out_taghit, out_illegal} = d[DEPTH-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      d <= '{default: '0};
    end else if (!stall) begin
      v[0] <= acc;
      d[0] <= acc ? dec : '0;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= '0;
      ill_cnt <= '0;
    end else begin
      hit_cnt <= cnt_clr ? '0 : (dlv & out_bit & ~&hit_cnt) ? hit_cnt + 1'b1 : hit_cnt;
      ill_cnt <= cnt_clr ? '0 : (dlv & out_illegal & ~&ill_cnt) ? ill_cnt + 1'b1 : ill_cnt;
    end
  end
endmodule

// File: tb/tb_x9dn_sel_pipe.sv
// tb_x9dn_sel_pipe: directed vector table plus stall, saturation and reset sequences
module tb_x9dn_sel_pipe;
  logic       clk, rst, in_valid, in_ready, cnt_clr, out_valid, out_ready;
  logic [5:0] addr;
  logic [2:0] mode;
  logic [3:0] lanes;
  logic [6:0] tag, tag_ref;
  logic       out_bcast, out_local, out_bit, out_taghit, out_illegal;
  logic [7:0] hit_cnt, ill_cnt;
  int         total = 0, bad = 0, exp_hit = 0, exp_ill = 0;
  typedef struct {
    logic [5:0] a;
    logic [2:0] m;
    logic [3:0] l;
    logic [6:0] t;
    logic [6:0] r;
    logic [4:0] e;
  } vec_t;
  vec_t tv [10];
  x9dn_sel_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .addr(addr), .mode(mode),
    .lanes(lanes), .tag(tag), .tag_ref(tag_ref), .cnt_clr(cnt_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_bcast(out_bcast), .out_local(out_local), .out_bit(out_bit),
    .out_taghit(out_taghit), .out_illegal(out_illegal), .hit_cnt(hit_cnt), .ill_cnt(ill_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [4:0] flags();
    return {out_bcast, out_local, out_bit, out_taghit, out_illegal};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [5:0] a, input logic [2:0] m, input logic [3:0] l,
                       input logic [6:0] t, input logic [6:0] r);
    addr = a; mode = m; lanes = l; tag = t; tag_ref = r; in_valid = 1'b1;
  endtask
  initial begin
    tv[0] = '{6'h3F, 3'd2, 4'b0100, 7'h11, 7'h11, 5'b10110};
    tv[1] = '{6'h00, 3'd1, 4'b1010, 7'h05, 7'h06, 5'b01100};
    tv[2] = '{6'h00, 3'd0, 4'b1010, 7'h7F, 7'h7F, 5'b01010};
    tv[3] = '{6'h15, 3'd3, 4'b1111, 7'h00, 7'h00, 5'b00010};
    tv[4] = '{6'h00, 3'd5, 4'b1111, 7'h12, 7'h13, 5'b01001};
    tv[5] = '{6'h3F, 3'd7, 4'b1111, 7'h40, 7'h40, 5'b10011};
    tv[6] = '{6'h3F, 3'd3, 4'b1000, 7'h01, 7'h02, 5'b10100};
    tv[7] = '{6'h01, 3'd0, 4'b0001, 7'h2A, 7'h2A, 5'b00010};
    tv[8] = '{6'h3E, 3'd1, 4'b1111, 7'h00, 7'h7F, 5'b00000};
    tv[9] = '{6'h00, 3'd4, 4'b1111, 7'h55, 7'h55, 5'b01011};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    addr = '0; mode = '0; lanes = '0; tag = '0; tag_ref = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_flags", flags(), 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_ill_cnt", ill_cnt, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(tv[k].a, tv[k].m, tv[k].l, tv[k].t, tv[k].r);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("vec%0d_early_valid", k), out_valid, 0);
      @(negedge clk);
      check($sformatf("vec%0d_valid", k), out_valid, 1);
      check($sformatf("vec%0d_flags", k), flags(), tv[k].e);
      exp_hit += tv[k].e[2];
      exp_ill += tv[k].e[0];
    end
    @(negedge clk);
    check("vec_hit_cnt", hit_cnt, exp_hit);
    check("vec_ill_cnt", ill_cnt, exp_ill);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        check($sformatf("b2b%0d_valid", c - 2), out_valid, 1);
        check($sformatf("b2b%0d_bit", c - 2), out_bit, ((c - 2) % 2) == 1);
      end
      if (c < 8) drive(6'h00, 3'(c % 4), 4'b1010, 7'h00, 7'h00);
      else in_valid = 1'b0;
    end
    exp_hit += 4;
    @(negedge clk);
    check("b2b_drained", out_valid, 0);
    check("b2b_hit_cnt", hit_cnt, exp_hit);
    @(negedge clk);
    drive(6'h3F, 3'd0, 4'b0001, 7'h09, 7'h09);
    @(negedge clk);
    drive(6'h00, 3'd1, 4'b0000, 7'h03, 7'h04);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b0;
      drive(6'h3F, 3'd1, 4'b1111, 7'h00, 7'h00);
      #1;
      check($sformatf("stall%0d_in_ready", k), in_ready, 0);
      check($sformatf("stall%0d_valid", k), out_valid, 1);
      check($sformatf("stall%0d_flags", k), flags(), 5'b10110);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b0;
    #1;
    check("stall_a_valid", out_valid, 1);
    check("stall_a_flags", flags(), 5'b10110);
    check("stall_in_ready", in_ready, 1);
    @(negedge clk);
    check("stall_b_valid", out_valid, 1);
    check("stall_b_flags", flags(), 5'b01000);
    @(negedge clk);
    exp_hit += 1;
    check("stall_no_dup", out_valid, 0);
    check("stall_hit_cnt", hit_cnt, exp_hit);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      drive(6'h3F, 3'd0, 4'b0001, 7'h00, 7'h00);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_hit = (exp_hit + 300 > 255) ? 255 : exp_hit + 300;
    check("sat_hit_cnt", hit_cnt, exp_hit);
    check("sat_ill_cnt", ill_cnt, exp_ill);
    drive(6'h3F, 3'd0, 4'b0001, 7'h00, 7'h00);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    cnt_clr = 1'b1;
    check("clr_beat_valid", out_valid, 1);
    check("clr_beat_bit", out_bit, 1);
    @(negedge clk);
    cnt_clr = 1'b0;
    exp_hit = 0;
    exp_ill = 0;
    check("clr_hit_cnt", hit_cnt, exp_hit);
    check("clr_ill_cnt", ill_cnt, exp_ill);
    drive(6'h00, 3'd3, 4'b1000, 7'h00, 7'h00);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_hit_cnt", hit_cnt, 1);
    drive(6'h3F, 3'd0, 4'b0001, 7'h00, 7'h00);
    @(negedge clk);
    drive(6'h00, 3'd5, 4'b1111, 7'h00, 7'h00);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_hit_cnt", hit_cnt, 0);
    check("rst_mid_ill_cnt", ill_cnt, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_mid_stale%0d", k), out_valid, 0);
    end
    check("rst_mid_hit_end", hit_cnt, 0);
    check("rst_mid_ill_end", ill_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
